addressing_write_scheduler: RTL and testbench
=============================================

Name: addressing_write_scheduler

Overview:
- Arbitrates writes into the five addressing memories (BBC, CTL, DO, PO, INC) between two sources: local writes from the addressing logic, issued in the owning thread's slot, and ALU writes already delayed by the write-sync pipeline.
- The ALU write always wins a same-cycle, same-memory conflict. The losing local write is deferred and replayed in that thread's next slot, unless a newer write supersedes it.
- Sits between the addressing units and the memory write ports.

Parameters:
- THREAD_COUNT, 8, number of hardware threads in the barrel.
- THREAD_COUNT_WIDTH, 3, width of the thread id.
- MEM_COUNT, 5, number of addressing memories; bit order BBC=0, CTL=1, DO=2, PO=3, INC=4.
- ADDR_WIDTH, 10, memory write-address width.
- WORD_WIDTH, 36, write-data width; narrower memories take the LSBs.
- DROP_COUNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- local_wren  in  MEM_COUNT  local write request per memory, for current_thread.
- local_addr  in  ADDR_WIDTH  local write address.
- local_data  in  WORD_WIDTH  local write data.
- alu_wren  in  MEM_COUNT  synced ALU write enable per memory.
- alu_addr  in  ADDR_WIDTH  synced ALU write address.
- alu_data  in  WORD_WIDTH  synced ALU write data.
- mem_wren  out  MEM_COUNT  registered write enable per memory.
- mem_addr  out  MEM_COUNT*ADDR_WIDTH  per-memory write address, memory m at slice [m*ADDR_WIDTH +: ADDR_WIDTH].
- mem_data  out  MEM_COUNT*WORD_WIDTH  per-memory write data, same slicing.
- current_thread  out  THREAD_COUNT_WIDTH  thread owning this cycle's slot.
- deferred_pending  out  1  deferred buffer occupied.
- drop_pulse  out  1  one-cycle pulse when any local write is discarded on overflow.
- drop_count  out  DROP_COUNT_WIDTH  saturating count of overflow discards.

Behaviour:
- Reset (synchronous, active-high; same cycle the clock edge sees reset=1):
  - All outputs go to 0: mem_wren, mem_addr, mem_data, current_thread, deferred_pending, drop_pulse, drop_count.
  - The deferred buffer is cleared.
  - Reset mid-replay discards the pending entry; no write issues.
- Thread slot: current_thread increments by 1 every cycle, wrapping THREAD_COUNT-1 -> 0. It is not stalled.
- Latency: arbitration is combinational on the inputs. The selected write appears on mem_* exactly 1 cycle later. mem_wren=0 leaves that memory's addr/data holding their last value.
- Per-memory selection, priority high to low:
  1. alu_wren[m]: issue alu_addr/alu_data.
  2. Replay: deferred entry covers m and this is its replay cycle.
  3. local_wren[m]: issue local_addr/local_data.
- Deferred buffer: single entry holding thread id, mem mask, addr and data.
- Conflict: local_wren[m] & alu_wren[m].
  - Buffer free, or freed this cycle by replay: capture the entry with thread=current_thread, mask = local_wren & alu_wren, and local addr/data. Non-conflicting bits of local_wren issue normally this cycle.
  - Buffer occupied and not replaying this cycle: the conflicting local bits are dropped; drop_pulse=1 next cycle; drop_count+1, saturating at all-ones. The buffer is unchanged.
- Replay cycle: deferred_pending & current_thread == deferred thread, i.e. exactly THREAD_COUNT cycles after capture. For each m in the mask:
  - alu_wren[m]: discard (newer ALU write wins). Not counted as a drop.
  - else local_wren[m]: discard (thread's newer local write supersedes). Not counted as a drop.
  - else issue the deferred addr/data on memory m.
  - The buffer clears at the end of the replay cycle. A new conflict in that same cycle recaptures (capture has priority over clear).
- Multiple memories may write in the same cycle from different sources (e.g. ALU on CTL, local on DO, replay on PO).

Decomposition:
- Shared package (addressing_pkg):
  - Constants: THREAD_COUNT, THREAD_COUNT_WIDTH, MEM_COUNT.
  - Memory-index constants: MEM_BBC=0, MEM_CTL=1, MEM_DO=2, MEM_PO=3, MEM_INC=4.
  - Deferred-entry record typedef: valid, thread, mask, addr, data.
- One natural sub-module: thread_slot_counter, a modulo-THREAD_COUNT counter with synchronous reset, reusable by other thread-synchronized blocks.

Test Plan:
- Reset, then idle 20 cycles -> all outputs 0; current_thread cycles 0..7 then 0; mem_wren never set.
- Local-only: thread 3, local_wren=00100, addr=0x12, data=5 -> next cycle mem_wren=00100, DO slice addr 0x12 data 5; no deferral.
- Conflict: thread 2, local_wren=alu_wren=00010, local addr 0x20/data 7, alu addr 0x30/data 9 -> CTL gets 0x30/9 next cycle, deferred_pending=1. 8 cycles later, no new writes -> CTL gets 0x20/7; deferred_pending drops to 0.
- Supersede: same as above, but at replay local_wren[1]=1 with addr 0x21 -> CTL gets 0x21 only; 0x20 never written; drop_count stays 0.
- Overflow: entry pending from thread 2; thread 5 conflicts on INC -> thread 5 INC local write discarded, drop_pulse=1 for one cycle, drop_count=1. Force 2^16+3 overflows -> drop_count saturates at 0xFFFF.
- Reset asserted 4 cycles after capture -> deferred_pending=0 next cycle; no replay write ever appears.

Source files
------------

// File: rtl/addressing_write_scheduler_pkg.sv
// Shared constants and the deferred-entry record for the addressing write scheduler.
package addressing_write_scheduler_pkg;

    localparam int THREAD_COUNT       = 8;
    localparam int THREAD_COUNT_WIDTH = 3;
    localparam int MEM_COUNT          = 5;
    localparam int ADDR_WIDTH         = 10;
    localparam int WORD_WIDTH         = 36;
    localparam int DROP_COUNT_WIDTH   = 16;

    // Bit positions of each addressing memory in the wren vectors.
    localparam int MEM_BBC = 0;
    localparam int MEM_CTL = 1;
    localparam int MEM_DO  = 2;
    localparam int MEM_PO  = 3;
    localparam int MEM_INC = 4;

    // One local write that lost to the ALU and waits for its thread's next slot.
    typedef struct packed {
        logic                          valid;
        logic [THREAD_COUNT_WIDTH-1:0] thread;
        logic [MEM_COUNT-1:0]          mask;
        logic [ADDR_WIDTH-1:0]         addr;
        logic [WORD_WIDTH-1:0]         data;
    } deferred_entry_t;

endpackage

// File: rtl/addressing_write_scheduler_if.sv
// Write bus between the write sources (local + synced ALU) and the memory write ports.
// Writes are fire-and-forget: a set wren bit is a write that cycle, there is no back-pressure.
interface addressing_write_scheduler_if;
    import addressing_write_scheduler_pkg::*;

    logic [MEM_COUNT-1:0]            local_wren;
    logic [ADDR_WIDTH-1:0]           local_addr;
    logic [WORD_WIDTH-1:0]           local_data;
    logic [MEM_COUNT-1:0]            alu_wren;
    logic [ADDR_WIDTH-1:0]           alu_addr;
    logic [WORD_WIDTH-1:0]           alu_data;
    logic [MEM_COUNT-1:0]            mem_wren;
    logic [MEM_COUNT*ADDR_WIDTH-1:0] mem_addr;
    logic [MEM_COUNT*WORD_WIDTH-1:0] mem_data;

    // Source side: issues requests, observes the memory write ports.
    modport master (
        output local_wren, local_addr, local_data,
        output alu_wren, alu_addr, alu_data,
        input  mem_wren, mem_addr, mem_data
    );

    // Scheduler side.
    modport slave (
        input  local_wren, local_addr, local_data,
        input  alu_wren, alu_addr, alu_data,
        output mem_wren, mem_addr, mem_data
    );

endinterface

// File: rtl/addressing_write_scheduler_thread_slot_counter.sv
// Free-running modulo-COUNT thread slot counter with synchronous reset.
module addressing_write_scheduler_thread_slot_counter #(
    parameter int COUNT = 8,
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Advance one slot per cycle, wrapping at COUNT-1.
    always_comb begin
        count_d = count_q + WIDTH'(1);
        if (count_q == WIDTH'(COUNT - 1)) begin
            count_d = '0;
        end
    end

    // Slot register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/addressing_write_scheduler.sv
// Arbitrates writes into the five addressing memories between local and synced ALU
// writes. ALU always wins a conflict; the losing local write is parked in a single
// deferred entry and replayed in the owning thread's next slot unless superseded.
module addressing_write_scheduler
    import addressing_write_scheduler_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset,
    addressing_write_scheduler_if.slave   bus,
    output logic [THREAD_COUNT_WIDTH-1:0] current_thread,
    output logic                          deferred_pending,
    output logic                          drop_pulse,
    output logic [DROP_COUNT_WIDTH-1:0]   drop_count
);

    deferred_entry_t                 deferred_q, deferred_d;
    logic [MEM_COUNT-1:0]            mem_wren_q, mem_wren_d;
    logic [MEM_COUNT*ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [MEM_COUNT*WORD_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                            drop_pulse_q, drop_pulse_d;
    logic [DROP_COUNT_WIDTH-1:0]     drop_count_q, drop_count_d;

    logic                 replay;
    logic                 can_capture;
    logic                 capture;
    logic                 drop;
    logic [MEM_COUNT-1:0] conflict;
    logic [MEM_COUNT-1:0] replay_issue;

    addressing_write_scheduler_thread_slot_counter #(
        .COUNT (THREAD_COUNT),
        .WIDTH (THREAD_COUNT_WIDTH)
    ) u_slot_counter (
        .clock (clock),
        .reset (reset),
        .count (current_thread)
    );

    // Conflict detection and replay qualification for this slot.
    always_comb begin
        replay       = deferred_q.valid && (deferred_q.thread == current_thread);
        conflict     = bus.local_wren & bus.alu_wren;
        // A replaying entry is vacated this cycle, so it can take a new capture.
        can_capture  = !deferred_q.valid || replay;
        capture      = (|conflict) && can_capture;
        drop         = (|conflict) && !can_capture;
        // Any newer write to the same memory this cycle, ALU or local, supersedes the replay.
        replay_issue = '0;
        if (replay) begin
            replay_issue = deferred_q.mask & ~bus.alu_wren & ~bus.local_wren;
        end
    end

    // Per-memory source select: ALU, then replay, then local; idle memories hold addr/data.
    always_comb begin
        mem_wren_d = '0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        for (int m = 0; m < MEM_COUNT; m++) begin
            if (bus.alu_wren[m]) begin
                mem_wren_d[m]                         = 1'b1;
                mem_addr_d[m*ADDR_WIDTH +: ADDR_WIDTH] = bus.alu_addr;
                mem_data_d[m*WORD_WIDTH +: WORD_WIDTH] = bus.alu_data;
            end else if (replay_issue[m]) begin
                mem_wren_d[m]                         = 1'b1;
                mem_addr_d[m*ADDR_WIDTH +: ADDR_WIDTH] = deferred_q.addr;
                mem_data_d[m*WORD_WIDTH +: WORD_WIDTH] = deferred_q.data;
            end else if (bus.local_wren[m]) begin
                mem_wren_d[m]                         = 1'b1;
                mem_addr_d[m*ADDR_WIDTH +: ADDR_WIDTH] = bus.local_addr;
                mem_data_d[m*WORD_WIDTH +: WORD_WIDTH] = bus.local_data;
            end
        end
    end

    // Deferred entry update: capture wins over the end-of-replay clear.
    always_comb begin
        deferred_d = deferred_q;
        if (capture) begin
            deferred_d.valid  = 1'b1;
            deferred_d.thread = current_thread;
            deferred_d.mask   = conflict;
            deferred_d.addr   = bus.local_addr;
            deferred_d.data   = bus.local_data;
        end else if (replay) begin
            deferred_d = '0;
        end
    end

    // Overflow accounting: one pulse per discarding cycle, saturating counter.
    always_comb begin
        drop_pulse_d = drop;
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != {DROP_COUNT_WIDTH{1'b1}})) begin
            drop_count_d = drop_count_q + DROP_COUNT_WIDTH'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            deferred_q   <= '0;
            mem_wren_q   <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            deferred_q   <= deferred_d;
            mem_wren_q   <= mem_wren_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign bus.mem_wren      = mem_wren_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_data      = mem_data_q;
    assign deferred_pending  = deferred_q.valid;
    assign drop_pulse        = drop_pulse_q;
    assign drop_count        = drop_count_q;

endmodule

// File: tb/tb_addressing_write_scheduler.sv
// Directed bench for addressing_write_scheduler with hand-computed expectations.
module tb_addressing_write_scheduler;
    import addressing_write_scheduler_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [THREAD_COUNT_WIDTH-1:0] current_thread;
    logic                          deferred_pending;
    logic                          drop_pulse;
    logic [DROP_COUNT_WIDTH-1:0]   drop_count;

    int errors = 0;
    int checks = 0;

    addressing_write_scheduler_if bus ();

    addressing_write_scheduler dut (
        .clock            (clock),
        .reset            (reset),
        .bus              (bus),
        .current_thread   (current_thread),
        .deferred_pending (deferred_pending),
        .drop_pulse       (drop_pulse),
        .drop_count       (drop_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input int m);
        return bus.mem_addr[m*ADDR_WIDTH +: ADDR_WIDTH];
    endfunction

    function automatic logic [WORD_WIDTH-1:0] data_of(input int m);
        return bus.mem_data[m*WORD_WIDTH +: WORD_WIDTH];
    endfunction

    task automatic clear_inputs();
        bus.local_wren = '0;
        bus.local_addr = '0;
        bus.local_data = '0;
        bus.alu_wren   = '0;
        bus.alu_addr   = '0;
        bus.alu_data   = '0;
    endtask

    task automatic drive_local(input logic [MEM_COUNT-1:0] wren, input logic [ADDR_WIDTH-1:0] addr,
                               input logic [WORD_WIDTH-1:0] data);
        bus.local_wren = wren;
        bus.local_addr = addr;
        bus.local_data = data;
    endtask

    task automatic drive_alu(input logic [MEM_COUNT-1:0] wren, input logic [ADDR_WIDTH-1:0] addr,
                             input logic [WORD_WIDTH-1:0] data);
        bus.alu_wren = wren;
        bus.alu_addr = addr;
        bus.alu_data = data;
    endtask

    // Advance until the slot belongs to thread t (bounded to two full rotations).
    task automatic wait_thread(input int t);
        int n = 0;
        while (current_thread != THREAD_COUNT_WIDTH'(t) && n < 16) begin
            tick();
            n++;
        end
        check("wait_thread", 64'(current_thread), 64'(t));
    endtask

    initial begin
        int exp_thr;
        int drops_seen;
        int cyc;

        // Reset
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        check("rst_wren", 64'(bus.mem_wren), 64'h0);
        check("rst_addr", 64'(|bus.mem_addr), 64'h0);
        check("rst_data", 64'(|bus.mem_data), 64'h0);
        check("rst_thread", 64'(current_thread), 64'h0);
        check("rst_pending", 64'(deferred_pending), 64'h0);
        check("rst_drop_pulse", 64'(drop_pulse), 64'h0);
        check("rst_drop_count", 64'(drop_count), 64'h0);
        reset = 1'b0;

        // Idle: slot counter rotates, nothing written
        exp_thr = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_thr = (exp_thr + 1) % THREAD_COUNT;
            check("idle_thread", 64'(current_thread), 64'(exp_thr));
            check("idle_wren", 64'(bus.mem_wren), 64'h0);
        end
        check("idle_pending", 64'(deferred_pending), 64'h0);

        // Local-only write on DO from thread 3
        wait_thread(3);
        drive_local(5'b00100, 10'h12, 36'd5);
        tick();
        clear_inputs();
        check("local_wren", 64'(bus.mem_wren), 64'b00100);
        check("local_addr", 64'(addr_of(MEM_DO)), 64'h12);
        check("local_data", 64'(data_of(MEM_DO)), 64'd5);
        check("local_bbc_addr", 64'(addr_of(MEM_BBC)), 64'h0);
        check("local_pending", 64'(deferred_pending), 64'h0);
        tick();
        check("local_idle_wren", 64'(bus.mem_wren), 64'h0);
        check("local_hold_addr", 64'(addr_of(MEM_DO)), 64'h12);

        // Conflict on CTL from thread 2, replayed 8 cycles later
        wait_thread(2);
        drive_local(5'b00010, 10'h20, 36'd7);
        drive_alu(5'b00010, 10'h30, 36'd9);
        tick();
        clear_inputs();
        check("conf_wren", 64'(bus.mem_wren), 64'b00010);
        check("conf_addr", 64'(addr_of(MEM_CTL)), 64'h30);
        check("conf_data", 64'(data_of(MEM_CTL)), 64'd9);
        check("conf_pending", 64'(deferred_pending), 64'h1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("conf_wait_wren", 64'(bus.mem_wren), 64'h0);
            check("conf_wait_pending", 64'(deferred_pending), 64'h1);
        end
        check("conf_wait_addr_hold", 64'(addr_of(MEM_CTL)), 64'h30);
        check("conf_replay_thread", 64'(current_thread), 64'h2);
        tick();
        check("replay_wren", 64'(bus.mem_wren), 64'b00010);
        check("replay_addr", 64'(addr_of(MEM_CTL)), 64'h20);
        check("replay_data", 64'(data_of(MEM_CTL)), 64'd7);
        check("replay_pending", 64'(deferred_pending), 64'h0);
        tick();
        check("replay_after_wren", 64'(bus.mem_wren), 64'h0);

        // Supersede: thread 2 writes CTL again in its replay slot
        wait_thread(2);
        drive_local(5'b00010, 10'h20, 36'd7);
        drive_alu(5'b00010, 10'h30, 36'd9);
        tick();
        clear_inputs();
        check("sup_alu_addr", 64'(addr_of(MEM_CTL)), 64'h30);
        check("sup_pending", 64'(deferred_pending), 64'h1);
        repeat (7) tick();
        drive_local(5'b00010, 10'h21, 36'h11);
        tick();
        clear_inputs();
        check("sup_wren", 64'(bus.mem_wren), 64'b00010);
        check("sup_addr", 64'(addr_of(MEM_CTL)), 64'h21);
        check("sup_data", 64'(data_of(MEM_CTL)), 64'h11);
        check("sup_pending", 64'(deferred_pending), 64'h0);
        check("sup_drop_count", 64'(drop_count), 64'h0);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("sup_no_old_write", 64'(bus.mem_wren), 64'h0);
        end

        // Three sources in one cycle: ALU on CTL, local on DO, replay on PO
        wait_thread(4);
        drive_local(5'b01000, 10'h40, 36'hA);
        drive_alu(5'b01000, 10'h41, 36'hB);
        tick();
        clear_inputs();
        check("multi_cap_wren", 64'(bus.mem_wren), 64'b01000);
        check("multi_cap_addr", 64'(addr_of(MEM_PO)), 64'h41);
        repeat (7) tick();
        drive_alu(5'b00010, 10'h42, 36'hC);
        drive_local(5'b00100, 10'h43, 36'hD);
        tick();
        clear_inputs();
        check("multi_wren", 64'(bus.mem_wren), 64'b01110);
        check("multi_po_addr", 64'(addr_of(MEM_PO)), 64'h40);
        check("multi_po_data", 64'(data_of(MEM_PO)), 64'hA);
        check("multi_ctl_addr", 64'(addr_of(MEM_CTL)), 64'h42);
        check("multi_ctl_data", 64'(data_of(MEM_CTL)), 64'hC);
        check("multi_do_addr", 64'(addr_of(MEM_DO)), 64'h43);
        check("multi_do_data", 64'(data_of(MEM_DO)), 64'hD);
        check("multi_pending", 64'(deferred_pending), 64'h0);

        // Overflow: entry pending for thread 2, thread 5 conflicts on INC
        wait_thread(2);
        drive_local(5'b00010, 10'h20, 36'd7);
        drive_alu(5'b00010, 10'h30, 36'd9);
        tick();
        clear_inputs();
        check("ovf_pending", 64'(deferred_pending), 64'h1);
        wait_thread(5);
        drive_local(5'b10000, 10'h55, 36'h3);
        drive_alu(5'b10000, 10'h66, 36'h4);
        tick();
        clear_inputs();
        check("ovf_wren", 64'(bus.mem_wren), 64'b10000);
        check("ovf_inc_addr", 64'(addr_of(MEM_INC)), 64'h66);
        check("ovf_inc_data", 64'(data_of(MEM_INC)), 64'h4);
        check("ovf_drop_pulse", 64'(drop_pulse), 64'h1);
        check("ovf_drop_count", 64'(drop_count), 64'h1);
        check("ovf_still_pending", 64'(deferred_pending), 64'h1);
        tick();
        check("ovf_pulse_clear", 64'(drop_pulse), 64'h0);
        check("ovf_count_hold", 64'(drop_count), 64'h1);
        wait_thread(2);
        tick();
        check("ovf_replay_wren", 64'(bus.mem_wren), 64'b00010);
        check("ovf_replay_addr", 64'(addr_of(MEM_CTL)), 64'h20);
        check("ovf_replay_pending", 64'(deferred_pending), 64'h0);

        // Saturation: continuous INC conflicts until well past 2^16 discards
        drive_local(5'b10000, 10'h55, 36'h3);
        drive_alu(5'b10000, 10'h66, 36'h4);
        drops_seen = 1;
        cyc = 0;
        while (drops_seen < 65539 && cyc < 80000) begin
            tick();
            cyc++;
            if (drop_pulse) drops_seen++;
        end
        clear_inputs();
        check("sat_drops_reached", 64'(drops_seen >= 65539), 64'h1);
        check("sat_drop_count", 64'(drop_count), 64'hFFFF);
        tick();
        check("sat_drop_count_hold", 64'(drop_count), 64'hFFFF);

        // Reset while an entry is pending: no replay may ever appear
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_drop_count", 64'(drop_count), 64'h0);
        check("rst2_pending", 64'(deferred_pending), 64'h0);
        check("rst2_thread", 64'(current_thread), 64'h0);
        wait_thread(2);
        drive_local(5'b00010, 10'h20, 36'd7);
        drive_alu(5'b00010, 10'h30, 36'd9);
        tick();
        clear_inputs();
        check("rst3_pending_before", 64'(deferred_pending), 64'h1);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst3_pending", 64'(deferred_pending), 64'h0);
        check("rst3_wren", 64'(bus.mem_wren), 64'h0);
        check("rst3_thread", 64'(current_thread), 64'h0);
        for (int i = 0; i < 16; i++) begin
            tick();
            check("rst3_no_replay", 64'(bus.mem_wren), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
